// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// csr_trap_ctrl : machine-mode CSR file, counters, exception/interrupt entry
// Rev 1.0
// ============================================================================
module csr_trap_ctrl #(
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned CNT_W       = 64,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0004,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               csr_valid,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic [29:0]        exc_pc,
    input  logic [31:0]        exc_tval,
    input  logic               int_ok,
    input  logic [29:0]        int_pc,
    input  logic               irq_soft,
    input  logic               irq_timer,
    input  logic [NUM_IRQ-1:0] irq_local,
    input  logic               mret,
    input  logic               retire,
    output logic               trap_take,
    output logic [31:0]        trap_target,
    output logic [31:0]        mepc_out
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MISA      = 12'h301;
    localparam logic [11:0] c_MIE       = 12'h304;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MTVAL     = 12'h343;
    localparam logic [11:0] c_MIP       = 12'h344;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_MVENDORID = 12'hF11;
    localparam logic [11:0] c_MARCHID   = 12'hF12;
    localparam logic [11:0] c_MIMPID    = 12'hF13;
    localparam logic [11:0] c_MHARTID   = 12'hF14;
    localparam logic [31:0] c_MIE_MASK  = 32'h0000_0088 | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

    logic             mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0]      mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0]      mcause_q, mcause_d, mtval_q, mtval_d;
    logic [29:0]      mepc_q, mepc_d;
    logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             illegal_q, illegal_d;

    logic [63:0] w_cyc64, w_ins64;
    logic [31:0] w_mstatus, w_mip, w_pend, w_old, w_wval, w_base;
    logic        w_perf, w_impl, w_eff_wr, w_illegal, w_wr, w_take_int, w_trap;
    logic [4:0]  w_int_code;

    assign w_cyc64   = 64'(mcycle_q);
    assign w_ins64   = 64'(minstret_q);
    assign w_mstatus = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
    assign w_perf    = (csr_addr >= 12'hB03 && csr_addr <= 12'hB1F) ||
                       (csr_addr >= 12'hB83 && csr_addr <= 12'hB9F) ||
                       (csr_addr >= 12'h323 && csr_addr <= 12'h33F);

    always_comb begin
        w_mip                  = '0;
        w_mip[3]               = irq_soft;
        w_mip[7]               = irq_timer;
        w_mip[16 +: NUM_IRQ]   = irq_local;
    end

    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (csr_addr)
            c_MSTATUS:   w_old = w_mstatus;
            c_MISA:      w_old = 32'h4000_0100;
            c_MIE:       w_old = mie_q;
            c_MTVEC:     w_old = mtvec_q;
            c_MSCRATCH:  w_old = mscratch_q;
            c_MEPC:      w_old = {mepc_q, 2'b00};
            c_MCAUSE:    w_old = mcause_q;
            c_MTVAL:     w_old = mtval_q;
            c_MIP:       w_old = w_mip;
            c_MCYCLE:    w_old = w_cyc64[31:0];
            c_MCYCLEH:   w_old = w_cyc64[63:32];
            c_MINSTRET:  w_old = w_ins64[31:0];
            c_MINSTRETH: w_old = w_ins64[63:32];
            c_MVENDORID, c_MARCHID, c_MIMPID: w_old = '0;
            c_MHARTID:   w_old = HART_ID;
            default:     w_impl = w_perf;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   w_wval = csr_wdata;
            2'b10:   w_wval = w_old | csr_wdata;
            2'b11:   w_wval = w_old & ~csr_wdata;
            default: w_wval = w_old;
        endcase
    end

    // Set/clear with a zero operand is a pure read: never writes, never faults on read-only space.
    assign w_eff_wr  = csr_valid && (csr_op == 2'b01 || (csr_op[1] && csr_wdata != 32'd0));
    assign w_illegal = csr_valid && (!w_impl || (w_eff_wr && csr_addr[11:10] == 2'b11));
    assign w_wr      = w_eff_wr && !w_illegal;

    // Lowest-priority source is scanned first so higher-priority hits overwrite it.
    always_comb begin
        w_pend     = w_mip & mie_q;
        w_int_code = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (w_pend[16 + i]) w_int_code = 5'(16 + i);
        end
        if (w_pend[7]) w_int_code = 5'd7;
        if (w_pend[3]) w_int_code = 5'd3;
    end

    assign w_take_int  = mst_mie_q && int_ok && (|w_pend) && !exc_valid;
    assign w_trap      = exc_valid || w_take_int;
    assign w_base      = {mtvec_q[31:2], 2'b00};
    assign trap_take   = w_trap;
    assign trap_target = (exc_valid || mtvec_q[1:0] != 2'b01) ? w_base
                                                              : w_base + {25'b0, w_int_code, 2'b00};
    assign mepc_out    = {mepc_q, 2'b00};
    assign csr_rdata   = rdata_q;
    assign csr_illegal = illegal_q;

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + CNT_W'(1);
        minstret_d = retire ? minstret_q + CNT_W'(1) : minstret_q;
        if (w_wr) begin
            case (csr_addr)
                c_MSTATUS: begin
                    mst_mie_d  = w_wval[3];
                    mst_mpie_d = w_wval[7];
                end
                c_MIE:       mie_d      = w_wval & c_MIE_MASK;
                c_MTVEC:     mtvec_d    = {w_wval[31:2], w_wval[1] ? mtvec_q[1:0] : w_wval[1:0]};
                c_MSCRATCH:  mscratch_d = w_wval;
                c_MEPC:      mepc_d     = w_wval[31:2];
                c_MCAUSE:    mcause_d   = w_wval;
                c_MTVAL:     mtval_d    = w_wval;
                c_MCYCLE:    mcycle_d   = CNT_W'({w_cyc64[63:32], w_wval});
                c_MCYCLEH:   mcycle_d   = CNT_W'({w_wval, w_cyc64[31:0]});
                c_MINSTRET:  minstret_d = CNT_W'({w_ins64[63:32], w_wval});
                c_MINSTRETH: minstret_d = CNT_W'({w_wval, w_ins64[31:0]});
                default: ;
            endcase
        end
        if (w_trap) begin
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            mepc_d     = exc_valid ? exc_pc : int_pc;
            mcause_d   = exc_valid ? {28'b0, exc_cause} : {1'b1, 26'b0, w_int_code};
            mtval_d    = exc_valid ? exc_tval : 32'd0;
        end else if (mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end
        rdata_d   = csr_valid ? (w_illegal ? 32'd0 : w_old) : rdata_q;
        illegal_d = w_illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            rdata_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            rdata_q    <= rdata_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// tb_csr_trap_ctrl : directed bench for csr_trap_ctrl (CNT_W=64 and CNT_W=32)
// Rev 1.0
// ============================================================================
module tb_csr_trap_ctrl;

    localparam int unsigned NUM_IRQ = 4;
    localparam logic [31:0] HART    = 32'h0000_0005;

    logic               clk = 1'b0;
    logic               reset;
    logic               csr_valid;
    logic [1:0]         csr_op;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic               exc_valid;
    logic [3:0]         exc_cause;
    logic [29:0]        exc_pc;
    logic [31:0]        exc_tval;
    logic               int_ok;
    logic [29:0]        int_pc;
    logic               irq_soft;
    logic               irq_timer;
    logic [NUM_IRQ-1:0] irq_local;
    logic               mret;
    logic               retire;

    logic [31:0] csr_rdata, trap_target, mepc_out;
    logic        csr_illegal, trap_take;
    logic [31:0] rdata32, target32, mepc32;
    logic        illegal32, take32;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.NUM_IRQ(NUM_IRQ), .CNT_W(64), .MTVEC_RESET(32'h4), .HART_ID(HART)) u_dut (
        .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .int_ok(int_ok), .int_pc(int_pc), .irq_soft(irq_soft), .irq_timer(irq_timer),
        .irq_local(irq_local), .mret(mret), .retire(retire), .trap_take(trap_take),
        .trap_target(trap_target), .mepc_out(mepc_out)
    );

    csr_trap_ctrl #(.NUM_IRQ(NUM_IRQ), .CNT_W(32), .MTVEC_RESET(32'h4), .HART_ID(HART)) u_dut32 (
        .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(rdata32), .csr_illegal(illegal32),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .int_ok(int_ok), .int_pc(int_pc), .irq_soft(irq_soft), .irq_timer(irq_timer),
        .irq_local(irq_local), .mret(mret), .retire(retire), .trap_take(take32),
        .trap_target(target32), .mepc_out(mepc32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        tick();
        csr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr(2'b00, addr, 32'd0);
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; csr_valid = 1'b1; csr_op = 2'b00; csr_addr = 12'h301; csr_wdata = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        int_ok = 1'b0; int_pc = '0; irq_soft = 1'b0; irq_timer = 1'b0; irq_local = '0;
        mret = 1'b0; retire = 1'b0;

        // Reset with a CSR read in flight: result discarded.
        repeat (3) tick();
        check("rst_rdata", csr_rdata, 32'd0);
        check("rst_illegal", 32'(csr_illegal), 32'd0);
        check("rst_take", 32'(trap_take), 32'd0);
        reset = 1'b0;
        csr_valid = 1'b0;
        tick();

        rd_chk("mtvec_rst", 12'h305, 32'h0000_0004);
        rd_chk("mstatus_rst", 12'h300, 32'h0000_1800);
        rd_chk("misa", 12'h301, 32'h4000_0100);
        rd_chk("mhartid", 12'hF14, HART);
        check("mhartid_ill", 32'(csr_illegal), 32'd0);

        // Vectored local interrupt 0.
        csr(2'b01, 12'h305, 32'h0000_0101);
        csr(2'b01, 12'h304, 32'h0001_0000);
        csr(2'b10, 12'h300, 32'h0000_0008);
        rd_chk("mstatus_mie", 12'h300, 32'h0000_1808);
        irq_local = 4'b0001; int_ok = 1'b1; int_pc = 30'h40;
        #1;
        check("irq0_take", 32'(trap_take), 32'd1);
        check("irq0_target", trap_target, 32'h0000_0140);
        tick();
        int_ok = 1'b0;
        #1;
        int_ok = 1'b1;
        #1;
        check("irq0_no_reenter", 32'(trap_take), 32'd0);
        int_ok = 1'b0;
        rd_chk("irq0_mcause", 12'h342, 32'h8000_0010);
        rd_chk("irq0_mepc", 12'h341, 32'h0000_0100);
        rd_chk("irq0_mstatus", 12'h300, 32'h0000_1880);
        irq_local = '0;

        // Exception beats simultaneous software+timer interrupts.
        csr(2'b01, 12'h304, 32'h0000_0088);
        csr(2'b10, 12'h300, 32'h0000_0008);
        irq_soft = 1'b1; irq_timer = 1'b1; int_ok = 1'b1;
        exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 30'h80; exc_tval = 32'd0;
        #1;
        check("exc_take", 32'(trap_take), 32'd1);
        check("exc_target", trap_target, 32'h0000_0100);
        tick();
        exc_valid = 1'b0; int_ok = 1'b0;

        // MRET right after the trap.
        mret = 1'b1;
        #1;
        check("mret_mepc_out", mepc_out, 32'h0000_0200);
        tick();
        mret = 1'b0;
        rd_chk("exc_mcause", 12'h342, 32'h0000_0002);
        rd_chk("exc_mip", 12'h344, 32'h0000_0088);
        rd_chk("exc_mepc", 12'h341, 32'h0000_0200);
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        // Software beats timer; vectored offset 4*3.
        int_ok = 1'b1; int_pc = 30'hC0;
        #1;
        check("soft_take", 32'(trap_take), 32'd1);
        check("soft_target", trap_target, 32'h0000_010C);
        tick();
        int_ok = 1'b0;
        rd_chk("soft_mcause", 12'h342, 32'h8000_0003);
        irq_soft = 1'b0;
        mret = 1'b1;
        tick();
        mret = 1'b0;
        int_ok = 1'b1;
        #1;
        check("timer_target", trap_target, 32'h0000_011C);
        tick();
        int_ok = 1'b0; irq_timer = 1'b0;
        rd_chk("timer_mcause", 12'h342, 32'h8000_0007);

        // MRET coincident with an exception is ignored.
        mret = 1'b1; exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 30'h100; exc_tval = 32'h1234;
        #1;
        check("mret_exc_take", 32'(trap_take), 32'd1);
        tick();
        mret = 1'b0; exc_valid = 1'b0;
        rd_chk("mret_exc_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("mret_exc_mcause", 12'h342, 32'h0000_000B);
        rd_chk("mret_exc_mtval", 12'h343, 32'h0000_1234);
        rd_chk("mret_exc_mepc", 12'h341, 32'h0000_0400);

        // minstret counts retire only; write wins over that edge.
        csr(2'b01, 12'hB02, 32'd0);
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        rd_chk("minstret", 12'hB02, 32'd3);

        // mcycle carry into upper half (64) vs wrap (32).
        csr(2'b01, 12'hB00, 32'hFFFF_FFF0);
        tick();
        csr_valid = 1'b1; csr_op = 2'b00; csr_addr = 12'hB00; csr_wdata = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_lo = 32'hFFFF_FFF1 + 32'(k);
            check("mcycle64", csr_rdata, exp_lo);
            check("mcycle32", rdata32, exp_lo);
        end
        csr_addr = 12'hB80;
        tick();
        csr_valid = 1'b0;
        check("mcycleh64", csr_rdata, 32'd1);
        check("mcycleh32", rdata32, 32'd0);

        // Illegal accesses and zero-operand set on read-only space.
        csr(2'b01, 12'hF11, 32'h55);
        check("wr_ro_ill", 32'(csr_illegal), 32'd1);
        check("wr_ro_rdata", csr_rdata, 32'd0);
        csr(2'b00, 12'h7C0, 32'd0);
        check("unimpl_ill", 32'(csr_illegal), 32'd1);
        csr(2'b10, 12'hF11, 32'd0);
        check("set0_ro_ill", 32'(csr_illegal), 32'd0);
        rd_chk("mvendorid", 12'hF11, 32'd0);
        check("mvendorid_ill", 32'(csr_illegal), 32'd0);

        // WARL fields and ignored writes.
        csr(2'b01, 12'h305, 32'h0000_0202);
        rd_chk("mtvec_mode2", 12'h305, 32'h0000_0201);
        csr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd_chk("mie_mask", 12'h304, 32'h000F_0088);
        csr(2'b01, 12'h344, 32'hFFFF_FFFF);
        check("mip_wr_ill", 32'(csr_illegal), 32'd0);
        rd_chk("mip_ro", 12'h344, 32'd0);
        csr(2'b01, 12'hB05, 32'd1);
        check("hpm_wr_ill", 32'(csr_illegal), 32'd0);
        rd_chk("hpm_rd", 12'hB05, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
